// File: rtl/uart_bus_periph.sv
// Memory-mapped 8N1 UART slave on the CPU data bus: TXD/RXD/CON registers,
// 16x oversampled receiver, tick-aligned transmitter and a level interrupt.
module uart_bus_periph #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned DIV      = CLK_FREQ / (BAUD * 16);
    localparam int unsigned CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [29:0] TXD_WORD = BASE_ADDR[31:2];
    localparam logic [29:0] RXD_WORD = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0] CON_WORD = BASE_ADDR[31:2] + 30'd2;

    typedef enum logic [2:0] {TX_IDLE, TX_SYNC, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic [CNT_W-1:0] div_cnt_r;
    logic             tick_s;
    logic             rxd_meta_r, rxd_sync_r;

    logic hit_txd_s, hit_rxd_s, hit_con_s;
    logic wr_txd_s, wr_con_s, rd_rxd_s, rd_con_s;

    tx_state_t   tx_state_r, tx_state_nxt_s;
    logic [3:0]  tx_tick_r, tx_tick_nxt_s;
    logic [2:0]  tx_bit_r, tx_bit_nxt_s;
    logic [7:0]  tx_shift_r, tx_shift_nxt_s;
    logic        txd_r, txd_nxt_s;
    logic [7:0]  tx_data_r;
    logic        tx_done_r, tx_accept_s, tx_finish_s, tx_busy_s;

    rx_state_t   rx_state_r, rx_state_nxt_s;
    logic [3:0]  rx_tick_r, rx_tick_nxt_s;
    logic [2:0]  rx_bit_r, rx_bit_nxt_s;
    logic [7:0]  rx_shift_r, rx_shift_nxt_s;
    logic        rx_byte_ok_s, rx_frame_bad_s;

    logic [7:0]  rx_data_r;
    logic        rx_valid_r, overrun_r, frame_err_r;
    logic        tx_int_en_r, rx_int_en_r;
    logic        unused_s;

    assign unused_s  = ^{addr[1:0], wdata[31:8]};
    assign tick_s    = (div_cnt_r == DIV_LAST);
    assign hit_txd_s = (addr[31:2] == TXD_WORD);
    assign hit_rxd_s = (addr[31:2] == RXD_WORD);
    assign hit_con_s = (addr[31:2] == CON_WORD);
    assign wr_txd_s  = wr & hit_txd_s;
    assign wr_con_s  = wr & hit_con_s;
    assign rd_rxd_s  = rd & hit_rxd_s;
    assign rd_con_s  = rd & hit_con_s;
    assign tx_busy_s = (tx_state_r != TX_IDLE);
    assign txd       = txd_r;
    assign irq       = (tx_int_en_r & tx_done_r) | (rx_int_en_r & rx_valid_r);

    // Baud tick divider, 16 ticks per bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Transmitter next-state; TX_SYNC holds the line idle until the next tick
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_tick_nxt_s  = tx_tick_r;
        tx_bit_nxt_s   = tx_bit_r;
        tx_shift_nxt_s = tx_shift_r;
        tx_accept_s    = 1'b0;
        tx_finish_s    = 1'b0;
        txd_nxt_s      = 1'b1;
        case (tx_state_r)
            TX_IDLE: begin
                if (wr_txd_s) begin
                    tx_state_nxt_s = TX_SYNC;
                    tx_shift_nxt_s = wdata[7:0];
                    tx_accept_s    = 1'b1;
                end else begin
                    tx_state_nxt_s = TX_IDLE;
                end
            end
            TX_SYNC: begin
                if (tick_s) begin
                    tx_state_nxt_s = TX_START;
                    tx_tick_nxt_s  = 4'd0;
                end else begin
                    tx_state_nxt_s = TX_SYNC;
                end
            end
            TX_START: begin
                if (tick_s && tx_tick_r == 4'd15) begin
                    tx_state_nxt_s = TX_DATA;
                    tx_tick_nxt_s  = 4'd0;
                    tx_bit_nxt_s   = 3'd0;
                end else if (tick_s) begin
                    tx_tick_nxt_s = tx_tick_r + 4'd1;
                end else begin
                    tx_tick_nxt_s = tx_tick_r;
                end
            end
            TX_DATA: begin
                if (tick_s && tx_tick_r == 4'd15) begin
                    tx_tick_nxt_s = 4'd0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_nxt_s = TX_STOP;
                    end else begin
                        tx_bit_nxt_s   = tx_bit_r + 3'd1;
                        tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else if (tick_s) begin
                    tx_tick_nxt_s = tx_tick_r + 4'd1;
                end else begin
                    tx_tick_nxt_s = tx_tick_r;
                end
            end
            TX_STOP: begin
                if (tick_s && tx_tick_r == 4'd15) begin
                    tx_state_nxt_s = TX_IDLE;
                    tx_tick_nxt_s  = 4'd0;
                    tx_finish_s    = 1'b1;
                end else if (tick_s) begin
                    tx_tick_nxt_s = tx_tick_r + 4'd1;
                end else begin
                    tx_tick_nxt_s = tx_tick_r;
                end
            end
            default: begin
                tx_state_nxt_s = TX_IDLE;
            end
        endcase
        case (tx_state_nxt_s)
            TX_START: txd_nxt_s = 1'b0;
            TX_DATA:  txd_nxt_s = tx_shift_nxt_s[0];
            default:  txd_nxt_s = 1'b1;
        endcase
    end

    // Transmitter state and registered line driver
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_tick_r  <= tx_tick_nxt_s;
            tx_bit_r   <= tx_bit_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            txd_r      <= txd_nxt_s;
        end
    end

    // Receiver next-state: start verified mid-bit, then one sample per 16 ticks
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_tick_nxt_s  = rx_tick_r;
        rx_bit_nxt_s   = rx_bit_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_byte_ok_s   = 1'b0;
        rx_frame_bad_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rxd_sync_r) begin
                    rx_state_nxt_s = RX_START;
                    rx_tick_nxt_s  = 4'd0;
                end else begin
                    rx_state_nxt_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (tick_s && rx_tick_r == 4'd7) begin
                    rx_tick_nxt_s = 4'd0;
                    rx_bit_nxt_s  = 3'd0;
                    if (rxd_sync_r) begin
                        rx_state_nxt_s = RX_IDLE;
                    end else begin
                        rx_state_nxt_s = RX_DATA;
                    end
                end else if (tick_s) begin
                    rx_tick_nxt_s = rx_tick_r + 4'd1;
                end else begin
                    rx_tick_nxt_s = rx_tick_r;
                end
            end
            RX_DATA: begin
                if (tick_s && rx_tick_r == 4'd15) begin
                    rx_tick_nxt_s  = 4'd0;
                    rx_shift_nxt_s = {rxd_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_nxt_s = RX_STOP;
                    end else begin
                        rx_bit_nxt_s = rx_bit_r + 3'd1;
                    end
                end else if (tick_s) begin
                    rx_tick_nxt_s = rx_tick_r + 4'd1;
                end else begin
                    rx_tick_nxt_s = rx_tick_r;
                end
            end
            RX_STOP: begin
                if (tick_s && rx_tick_r == 4'd15) begin
                    rx_tick_nxt_s  = 4'd0;
                    rx_state_nxt_s = RX_WAIT;
                    if (rxd_sync_r) begin
                        rx_byte_ok_s = 1'b1;
                    end else begin
                        rx_frame_bad_s = 1'b1;
                    end
                end else if (tick_s) begin
                    rx_tick_nxt_s = rx_tick_r + 4'd1;
                end else begin
                    rx_tick_nxt_s = rx_tick_r;
                end
            end
            RX_WAIT: begin
                if (rxd_sync_r) begin
                    rx_state_nxt_s = RX_IDLE;
                end else begin
                    rx_state_nxt_s = RX_WAIT;
                end
            end
            default: begin
                rx_state_nxt_s = RX_IDLE;
            end
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            rx_tick_r  <= rx_tick_nxt_s;
            rx_bit_r   <= rx_bit_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
        end
    end

    // Status flags and bus-visible registers; set events beat read-clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data_r   <= 8'h00;
            tx_done_r   <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            tx_int_en_r <= 1'b0;
            rx_int_en_r <= 1'b0;
        end else begin
            if (tx_accept_s) begin
                tx_data_r <= wdata[7:0];
            end else begin
                tx_data_r <= tx_data_r;
            end
            if (tx_finish_s) begin
                tx_done_r <= 1'b1;
            end else if (tx_accept_s || rd_con_s) begin
                tx_done_r <= 1'b0;
            end else begin
                tx_done_r <= tx_done_r;
            end
            if (rx_byte_ok_s) begin
                rx_data_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
                overrun_r  <= (rx_valid_r | overrun_r) & ~rd_rxd_s;
            end else if (rd_rxd_s) begin
                rx_valid_r <= 1'b0;
                overrun_r  <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
                overrun_r  <= overrun_r;
            end
            if (rx_frame_bad_s) begin
                frame_err_r <= 1'b1;
            end else if (rd_con_s) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
            if (wr_con_s) begin
                tx_int_en_r <= wdata[0];
                rx_int_en_r <= wdata[1];
            end else begin
                tx_int_en_r <= tx_int_en_r;
                rx_int_en_r <= rx_int_en_r;
            end
        end
    end

    // Read mux; zero when not selected so the top can OR slaves together
    always_comb begin
        rdata = 32'h0000_0000;
        if (rd && hit_txd_s) begin
            rdata = {24'h00_0000, tx_data_r};
        end else if (rd && hit_rxd_s) begin
            rdata = {24'h00_0000, rx_data_r};
        end else if (rd && hit_con_s) begin
            rdata = {25'h000_0000, overrun_r, frame_err_r, tx_busy_s,
                     rx_valid_r, tx_done_r, rx_int_en_r, tx_int_en_r};
        end else begin
            rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_uart_bus_periph.sv
// Directed self-checking bench for uart_bus_periph (DIV=4, one bit = 64 clk).
module tb_uart_bus_periph;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rxd = 1'b1;
    logic        txd;
    logic        irq;

    int checks = 0;
    int passed = 0;

    uart_bus_periph #(.CLK_FREQ(640), .BAUD(10), .BASE_ADDR(32'h4000_0018)) dut (
        .clk(clk), .reset(reset), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .rdata(rdata), .rxd(rxd), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; addr = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd = 1'b0; addr = 32'h0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (64) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (5) @(negedge clk);
        checks++; if (txd !== 1'b1) $display("FAIL rst_txd: got %b expected 1", txd); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq); else passed++;
        reset = 1'b1;
        bus_read(A_CON, v);
        checks++; if (v !== 32'h0) $display("FAIL rst_con: got %h expected 00000000", v); else passed++;
        bus_read(A_TXD, v);
        checks++; if (v !== 32'h0) $display("FAIL rst_txd_reg: got %h expected 00000000", v); else passed++;
        bus_read(32'h4000_0024, v);
        checks++; if (v !== 32'h0) $display("FAIL unmapped_read: got %h expected 00000000", v); else passed++;
        @(negedge clk);
        addr = A_CON; rd = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0) $display("FAIL rd_low: got %h expected 00000000", rdata); else passed++;
        addr = 32'h0;
    endtask

    // Sends one byte and checks every line level at mid-bit, optionally
    // attempting a second TXD write while the frame is in progress.
    task automatic tx_frame(input logic [7:0] b, input bit inject, input string name);
        logic [9:0]  lvl;
        logic [31:0] v;
        int n, skip;
        lvl = {1'b1, b, 1'b0};
        skip = 0;
        bus_write(A_TXD, {24'h0, b});
        n = 0;
        while (txd === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (txd !== 1'b0) $display("FAIL %s_start_wait: got %b expected 0", name, txd); else passed++;
        for (int i = 0; i < 10; i++) begin
            repeat (((i == 0) ? 32 : 64) - skip) @(negedge clk);
            skip = 0;
            checks++;
            if (txd !== lvl[i]) $display("FAIL %s_bit%0d: got %b expected %b", name, i, txd, lvl[i]);
            else passed++;
            addr = A_CON; rd = 1'b1;
            #1;
            checks++;
            if (rdata[4] !== 1'b1) $display("FAIL %s_busy%0d: got %b expected 1", name, i, rdata[4]);
            else passed++;
            rd = 1'b0;
            if (inject && i == 2) begin
                addr = A_TXD; wdata = 32'h3C; wr = 1'b1;
                @(negedge clk);
                wr = 1'b0;
                skip = 1;
            end
            addr = 32'h0;
        end
        repeat (40) @(negedge clk);
        bus_read(A_CON, v);
        checks++; if (v !== 32'h4) $display("FAIL %s_done: got %h expected 00000004", name, v); else passed++;
        bus_read(A_CON, v);
        checks++; if (v !== 32'h0) $display("FAIL %s_done_clr: got %h expected 00000000", name, v); else passed++;
    endtask

    task automatic test_tx_a5();
        tx_frame(8'hA5, 1'b0, "tx_a5");
    endtask

    task automatic test_tx_busy_write();
        logic [31:0] v;
        int lows;
        tx_frame(8'hA5, 1'b1, "tx_busywr");
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) $display("FAIL busywr_idle: got %0d low cycles expected 0", lows); else passed++;
        bus_read(A_TXD, v);
        checks++; if (v !== 32'hA5) $display("FAIL busywr_txd_reg: got %h expected 000000a5", v); else passed++;
    endtask

    task automatic test_rx_irq();
        logic [31:0] v;
        bus_write(A_CON, 32'h2);
        checks++; if (irq !== 1'b0) $display("FAIL rx_irq_pre: got %b expected 0", irq); else passed++;
        send_rx(8'h5A, 1'b1);
        checks++; if (irq !== 1'b1) $display("FAIL rx_irq_set: got %b expected 1", irq); else passed++;
        bus_read(A_CON, v);
        checks++; if (v !== 32'h0A) $display("FAIL rx_con: got %h expected 0000000a", v); else passed++;
        bus_read(A_RXD, v);
        checks++; if (v !== 32'h5A) $display("FAIL rx_data: got %h expected 0000005a", v); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL rx_irq_clr: got %b expected 0", irq); else passed++;
        bus_read(A_CON, v);
        checks++; if (v !== 32'h02) $display("FAIL rx_con_clr: got %h expected 00000002", v); else passed++;
    endtask

    task automatic test_overrun_frame_err();
        logic [31:0] v;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(A_CON, v);
        checks++; if (v !== 32'h4A) $display("FAIL ovr_con: got %h expected 0000004a", v); else passed++;
        send_rx(8'h77, 1'b0);
        bus_read(A_CON, v);
        checks++; if (v !== 32'h6A) $display("FAIL ferr_con: got %h expected 0000006a", v); else passed++;
        bus_read(A_RXD, v);
        checks++; if (v !== 32'h22) $display("FAIL ferr_rxd: got %h expected 00000022", v); else passed++;
        bus_read(A_CON, v);
        checks++; if (v !== 32'h02) $display("FAIL ferr_con_clr: got %h expected 00000002", v); else passed++;
    endtask

    task automatic test_glitch_and_reset();
        logic [31:0] v;
        int n;
        @(negedge clk);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(A_CON, v);
        checks++; if (v !== 32'h02) $display("FAIL glitch_con: got %h expected 00000002", v); else passed++;
        bus_write(A_TXD, 32'h00);
        n = 0;
        while (txd === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        checks++; if (txd !== 1'b0) $display("FAIL midframe_txd: got %b expected 0", txd); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (txd !== 1'b1) $display("FAIL reset_txd_async: got %b expected 1", txd); else passed++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_read(A_CON, v);
        checks++; if (v !== 32'h0) $display("FAIL reset_con: got %h expected 00000000", v); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else passed++;
        repeat (200) @(negedge clk);
        checks++; if (txd !== 1'b1) $display("FAIL reset_txd_idle: got %b expected 1", txd); else passed++;
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_tx_busy_write();
        test_rx_irq();
        test_overrun_frame_err();
        test_glitch_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
